// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - Sequencer <-> datapath/memory signal bundle for the multi-cycle core
interface mc_ctrl_if;
  logic [31:0] memRdata;
  logic        memReady;
  logic        brTaken;
  logic [31:0] ir;
  logic        irWr;
  logic        mdrWr;
  logic        pcWr;
  logic        memRd;
  logic        memWr;
  logic        iorD;
  logic [1:0]  pcSrc;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic [4:0]  aluOp;
  logic        extOp;
  logic        regWr;
  logic [1:0]  regDst;
  logic [1:0]  memToReg;
  logic        insDone;
  logic        illegal;

  modport master (
    input  memRdata, memReady, brTaken,
    output ir, irWr, mdrWr, pcWr, memRd, memWr, iorD, pcSrc, aluSrcA, aluSrcB,
           aluOp, extOp, regWr, regDst, memToReg, insDone, illegal
  );

  modport slave (
    output memRdata, memReady, brTaken,
    input  ir, irWr, mdrWr, pcWr, memRd, memWr, iorD, pcSrc, aluSrcA, aluSrcB,
           aluOp, extOp, regWr, regDst, memToReg, insDone, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - Moore sequencer for the shared-memory multi-cycle MIPS-subset datapath
module mc_ctrl (
  input  logic      clk,
  input  logic      rstn,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    START, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP
  } state_t;

  typedef enum logic [2:0] {
    K_ILL, K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BR, K_JMP
  } kind_t;

  typedef struct packed {
    logic       memRd;
    logic       memWr;
    logic       iorD;
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [4:0] aluOp;
    logic       extOp;
    logic       regWr;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       insDone;
    logic       illegal;
  } moore_t;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_NOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;
  localparam logic [4:0] ALU_SLLV = 5'b01100;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SRAV = 5'b01110;
  localparam logic [4:0] ALU_SRLV = 5'b01111;
  localparam logic [4:0] ALU_LUI  = 5'b10000;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    kind_t k;
    k = K_ILL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_JR, FN_JALR: k = K_JMP;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
            k = K_ALU_R;
          default: k = K_ILL;
        endcase
      end
      OP_J, OP_JAL:                                    k = K_JMP;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:     k = K_BR;
      OP_LB, OP_LBU, OP_LW:                            k = K_LOAD;
      OP_SB, OP_SW:                                    k = K_STORE;
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        k = K_ALU_I;
      default:                                         k = K_ILL;
    endcase
    return k;
  endfunction

  // Returns {extOp, aluOp} for the EXEC step of an ALU instruction.
  function automatic logic [5:0] alu_ctl(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] r;
    r = {1'b0, ALU_ADD};
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB, FN_SUBU: r = {1'b0, ALU_SUB};
        FN_SLT:          r = {1'b0, ALU_SLT};
        FN_SLTU:         r = {1'b0, ALU_SLTU};
        FN_AND:          r = {1'b0, ALU_AND};
        FN_OR:           r = {1'b0, ALU_OR};
        FN_XOR:          r = {1'b0, ALU_XOR};
        FN_NOR:          r = {1'b0, ALU_NOR};
        FN_SLL:          r = {1'b0, ALU_SLL};
        FN_SRL:          r = {1'b0, ALU_SRL};
        FN_SRA:          r = {1'b0, ALU_SRA};
        FN_SLLV:         r = {1'b0, ALU_SLLV};
        FN_SRLV:         r = {1'b0, ALU_SRLV};
        FN_SRAV:         r = {1'b0, ALU_SRAV};
        default:         r = {1'b0, ALU_ADD};
      endcase
    end else begin
      case (op)
        OP_ADDIU: r = {1'b1, ALU_ADD};
        OP_SLTI:  r = {1'b1, ALU_SLT};
        OP_SLTIU: r = {1'b0, ALU_SLTU};
        OP_ANDI:  r = {1'b0, ALU_AND};
        OP_ORI:   r = {1'b0, ALU_OR};
        OP_XORI:  r = {1'b0, ALU_XOR};
        OP_LUI:   r = {1'b0, ALU_LUI};
        default:  r = {1'b0, ALU_ADD};
      endcase
    end
    return r;
  endfunction

  // Unqualified Moore strobes for a state; memReady/brTaken gating is applied at the ports.
  function automatic moore_t moore(input state_t s, input logic [5:0] op, input logic [5:0] fn);
    moore_t m;
    m = '0;
    case (s)
      FETCH:  m.memRd = 1'b1;
      DECODE: begin
        m.aluSrcB = 2'b11;
        m.aluOp   = ALU_ADD;
        m.illegal = (classify(op, fn) == K_ILL);
      end
      EXEC: begin
        m.aluSrcA            = 1'b1;
        m.aluSrcB            = (op == OP_RTYPE) ? 2'b00 : 2'b10;
        {m.extOp, m.aluOp}   = alu_ctl(op, fn);
      end
      ALUWB: begin
        m.regWr   = 1'b1;
        m.regDst  = (op == OP_RTYPE) ? 2'b01 : 2'b00;
        m.insDone = 1'b1;
      end
      MEMADR: begin
        m.aluSrcA = 1'b1;
        m.aluSrcB = 2'b10;
        m.extOp   = 1'b1;
        m.aluOp   = ALU_ADD;
      end
      MEMRD: begin
        m.memRd = 1'b1;
        m.iorD  = 1'b1;
      end
      MEMWB: begin
        m.regWr    = 1'b1;
        m.memToReg = 2'b01;
        m.insDone  = 1'b1;
      end
      MEMWR: begin
        m.memWr = 1'b1;
        m.iorD  = 1'b1;
      end
      BRANCH: begin
        m.aluSrcA = 1'b1;
        m.aluOp   = ALU_SUB;
        m.pcSrc   = 2'b11;
        m.insDone = 1'b1;
      end
      JUMP: begin
        m.pcWr    = 1'b1;
        m.insDone = 1'b1;
        m.pcSrc   = (op == OP_RTYPE) ? 2'b10 : 2'b01;
        // Both link forms write the PC register, which already holds the return address.
        if (op == OP_JAL) begin
          m.regWr    = 1'b1;
          m.regDst   = 2'b10;
          m.memToReg = 2'b10;
        end else if (op == OP_RTYPE && fn == FN_JALR) begin
          m.regWr    = 1'b1;
          m.regDst   = 2'b01;
          m.memToReg = 2'b10;
        end
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  state_t      r_state;
  logic [31:0] r_ir;
  moore_t      r_mo;
  state_t      w_next_state;
  logic [31:0] w_next_ir;
  kind_t       w_kind;

  assign w_kind = classify(r_ir[31:26], r_ir[5:0]);

  always_comb begin
    w_next_state = r_state;
    w_next_ir    = r_ir;
    case (r_state)
      START: w_next_state = FETCH;
      FETCH: begin
        if (bus.memReady) begin
          w_next_state = DECODE;
          w_next_ir    = bus.memRdata;
        end
      end
      DECODE: begin
        case (w_kind)
          K_ALU_R, K_ALU_I: w_next_state = EXEC;
          K_LOAD, K_STORE:  w_next_state = MEMADR;
          K_BR:             w_next_state = BRANCH;
          K_JMP:            w_next_state = JUMP;
          default:          w_next_state = FETCH;
        endcase
      end
      EXEC:   w_next_state = ALUWB;
      MEMADR: w_next_state = (w_kind == K_LOAD) ? MEMRD : MEMWR;
      MEMRD:  w_next_state = bus.memReady ? MEMWB : MEMRD;
      MEMWR:  w_next_state = bus.memReady ? FETCH : MEMWR;
      ALUWB, MEMWB, BRANCH, JUMP: w_next_state = FETCH;
      default: w_next_state = START;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free Moore outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= START;
      r_ir    <= '0;
      r_mo    <= '0;
    end else begin
      r_state <= w_next_state;
      r_ir    <= w_next_ir;
      r_mo    <= moore(w_next_state, w_next_ir[31:26], w_next_ir[5:0]);
    end
  end

  logic w_fetch_ack;
  assign w_fetch_ack = (r_state == FETCH) && bus.memReady;

  assign bus.ir       = r_ir;
  assign bus.irWr     = w_fetch_ack;
  assign bus.mdrWr    = (r_state == MEMRD) && bus.memReady;
  assign bus.pcWr     = r_mo.pcWr | w_fetch_ack | ((r_state == BRANCH) && bus.brTaken);
  assign bus.memRd    = r_mo.memRd;
  assign bus.memWr    = r_mo.memWr;
  assign bus.iorD     = r_mo.iorD;
  assign bus.pcSrc    = r_mo.pcSrc;
  assign bus.aluSrcA  = r_mo.aluSrcA;
  assign bus.aluSrcB  = r_mo.aluSrcB;
  assign bus.aluOp    = r_mo.aluOp;
  assign bus.extOp    = r_mo.extOp;
  assign bus.regWr    = r_mo.regWr;
  assign bus.regDst   = r_mo.regDst;
  assign bus.memToReg = r_mo.memToReg;
  assign bus.insDone  = r_mo.insDone | ((r_state == MEMWR) && bus.memReady);
  assign bus.illegal  = r_mo.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - Randomized scoreboard bench for mc_ctrl against an instruction-level model
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();
  mc_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          dw;
    logic        bt;
  } stim_t;

  typedef struct {
    logic [31:0] ins;
    int          cycles;
    logic        ill;
    logic        has_alu;
    logic [4:0]  aluOp;
    logic [1:0]  aluSrcB;
    logic        extOp;
    logic [8:0]  ret;
    int          mdr;
  } exp_t;

  stim_t prog_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    retired  = 0;
  int    n_prog   = 0;
  bit    drv_en   = 0;
  bit    mon_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic logic [23:0] all_outs();
    return {bus.irWr, bus.mdrWr, bus.pcWr, bus.memRd, bus.memWr, bus.iorD, bus.pcSrc,
            bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.extOp, bus.regWr, bus.regDst,
            bus.memToReg, bus.insDone, bus.illegal};
  endfunction

  // Instruction-level model: class, cycle budget and retire-cycle strobes.
  // ret = {memWr, regWr, regDst, memToReg, pcWr, pcSrc}
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [5:0] op, fn;
    int k;
    logic [4:0] a;
    logic x;
    op = s.ins[31:26]; fn = s.ins[5:0]; k = 0; a = 5'd0; x = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: begin k = 1; a = 5'd0;  end
        6'h22, 6'h23: begin k = 1; a = 5'd1;  end
        6'h2A:        begin k = 1; a = 5'd2;  end
        6'h24:        begin k = 1; a = 5'd3;  end
        6'h27:        begin k = 1; a = 5'd4;  end
        6'h25:        begin k = 1; a = 5'd5;  end
        6'h26:        begin k = 1; a = 5'd6;  end
        6'h00:        begin k = 1; a = 5'd7;  end
        6'h02:        begin k = 1; a = 5'd8;  end
        6'h2B:        begin k = 1; a = 5'd9;  end
        6'h04:        begin k = 1; a = 5'd12; end
        6'h03:        begin k = 1; a = 5'd13; end
        6'h07:        begin k = 1; a = 5'd14; end
        6'h06:        begin k = 1; a = 5'd15; end
        6'h08:        k = 8;
        6'h09:        k = 9;
        default:      k = 0;
      endcase
    end else begin
      case (op)
        6'h09: begin k = 2; a = 5'd0;  x = 1'b1; end
        6'h0A: begin k = 2; a = 5'd2;  x = 1'b1; end
        6'h0B: begin k = 2; a = 5'd9;  end
        6'h0C: begin k = 2; a = 5'd3;  end
        6'h0D: begin k = 2; a = 5'd5;  end
        6'h0E: begin k = 2; a = 5'd6;  end
        6'h0F: begin k = 2; a = 5'd16; end
        6'h20, 6'h23, 6'h24: k = 3;
        6'h28, 6'h2B:        k = 4;
        6'h01, 6'h04, 6'h05, 6'h06, 6'h07: k = 5;
        6'h02: k = 6;
        6'h03: k = 7;
        default: k = 0;
      endcase
    end
    e.ins = s.ins; e.ill = 1'b0; e.has_alu = 1'b1; e.aluOp = a; e.aluSrcB = 2'b00;
    e.extOp = x; e.mdr = 0; e.ret = '0; e.cycles = 3 + s.fw;
    case (k)
      1: begin e.cycles = 4 + s.fw; e.ret = 9'b0_1_01_00_0_00; end
      2: begin e.cycles = 4 + s.fw; e.aluSrcB = 2'b10; e.ret = 9'b0_1_00_00_0_00; end
      3: begin
        e.cycles = 5 + s.fw + s.dw; e.aluOp = 5'd0; e.aluSrcB = 2'b10; e.extOp = 1'b1;
        e.ret = 9'b0_1_00_01_0_00; e.mdr = 1;
      end
      4: begin
        e.cycles = 4 + s.fw + s.dw; e.aluOp = 5'd0; e.aluSrcB = 2'b10; e.extOp = 1'b1;
        e.ret = 9'b1_0_00_00_0_00;
      end
      5: begin e.aluOp = 5'd1; e.extOp = 1'b0; e.ret = {6'b0_0_00_00, s.bt, 2'b11}; end
      6: begin e.has_alu = 1'b0; e.ret = 9'b0_0_00_00_1_01; end
      7: begin e.has_alu = 1'b0; e.ret = 9'b0_1_10_10_1_01; end
      8: begin e.has_alu = 1'b0; e.ret = 9'b0_0_00_00_1_10; end
      9: begin e.has_alu = 1'b0; e.ret = 9'b0_1_01_10_1_10; end
      default: begin e.cycles = 2 + s.fw; e.ill = 1'b1; e.has_alu = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic add(input logic [31:0] ins, input int fw, input int dw, input logic bt);
    stim_t s;
    s.ins = ins; s.fw = fw; s.dw = dw; s.bt = bt;
    prog_q.push_back(s);
    n_prog++;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [20];
    logic [5:0] fns [18];
    logic [31:0] w;
    ops = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h2B};
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20,
            6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[31:26] = ops[$urandom_range(0, 19)];
    if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0) w[5:0] = fns[$urandom_range(0, 17)];
    return w;
  endfunction

  // Memory/datapath responder: supplies the program and the wait states chosen per instruction.
  initial begin : driver
    stim_t cur;
    bit    factive;
    int    fw, dw;
    factive = 0; fw = 0; dw = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!drv_en) continue;
      bus.memReady = 1'b0;
      bus.memRdata = $urandom;
      if (bus.memRd && !bus.iorD) begin
        if (!factive && prog_q.size() > 0) begin
          cur = prog_q.pop_front();
          fw = cur.fw; dw = cur.dw; factive = 1;
          exp_q.push_back(model(cur));
          bus.brTaken = cur.bt;
        end
        if (factive) begin
          bus.memRdata = cur.ins;
          if (fw == 0) begin
            bus.memReady = 1'b1;
            factive = 0;
          end else fw--;
        end
      end else if ((bus.memRd || bus.memWr) && bus.iorD) begin
        if (dw == 0) bus.memReady = 1'b1;
        else dw--;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit   busy;
    int   cyc, mdr, irw, ovl;
    bit   seen;
    logic [4:0] sop;
    logic [1:0] ssb;
    logic sext;
    busy = 0; cyc = 0; mdr = 0; irw = 0; ovl = 0; seen = 0; sop = '0; ssb = '0; sext = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        busy = 0;
        continue;
      end
      if (!busy && bus.memRd && !bus.iorD) begin
        busy = 1; cyc = 0; mdr = 0; irw = 0; ovl = 0; seen = 0;
      end
      if (!busy) continue;
      cyc++;
      if (bus.memRd && bus.memWr) ovl++;
      if (bus.mdrWr) mdr++;
      if (bus.irWr) irw++;
      if (bus.aluSrcA) begin
        seen = 1; sop = bus.aluOp; ssb = bus.aluSrcB; sext = bus.extOp;
      end
      if (bus.insDone || bus.illegal) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("cycles", 64'(cyc), 64'(e.cycles));
          check("ir", 64'(bus.ir), 64'(e.ins));
          check("illegal_pulse", 64'(bus.illegal), 64'(e.ill));
          check("insdone_pulse", 64'(bus.insDone), 64'(!e.ill));
          check("retire_strobes", 64'({bus.memWr, bus.regWr, bus.regDst, bus.memToReg,
                                       bus.pcWr, bus.pcSrc}), 64'(e.ret));
          check("alu_used", 64'(seen), 64'(e.has_alu));
          if (e.has_alu) check("alu_ctl", 64'({sop, ssb, sext}), 64'({e.aluOp, e.aluSrcB, e.extOp}));
          check("mdr_wr_count", 64'(mdr), 64'(e.mdr));
          check("ir_wr_count", 64'(irw), 64'd1);
          check("rd_wr_overlap", 64'(ovl), 64'd0);
        end
        retired++;
        busy = 0;
      end
    end
  end

  initial begin : main
    int t;
    rstn = 1'b0;
    bus.memReady = 1'b1;
    bus.memRdata = 32'hDEADBEEF;
    bus.brTaken  = 1'b1;

    add(32'h00221821, 0, 0, 1'b0);
    add(32'h8C220004, 0, 2, 1'b0);
    add(32'h10220003, 0, 0, 1'b0);
    add(32'h10220003, 0, 0, 1'b1);
    add(32'h0C000010, 0, 0, 1'b0);
    add(32'h03E00008, 1, 0, 1'b0);
    add(32'hFC000000, 0, 0, 1'b0);
    add(32'h0000003F, 0, 0, 1'b0);
    add(32'h20010005, 0, 0, 1'b0);
    add(32'hAC220008, 2, 1, 1'b0);
    for (int i = 0; i < 300; i++)
      add(rand_ins(), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    add(32'hAC220008, 0, 10, 1'b0);

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    check("reset_ir", 64'(bus.ir), 64'd0);

    @(posedge clk);
    #1;
    rstn = 1'b1;
    drv_en = 1;
    mon_en = 1;
    @(negedge clk);
    check("start_idle", 64'(all_outs()), 64'd0);
    @(negedge clk);
    check("first_fetch", 64'({bus.memRd, bus.iorD, bus.memWr}), 64'b100);

    t = 0;
    while (!(prog_q.size() == 0 && bus.memWr) && t < 40000) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("program_timeout", 64'(t < 40000), 64'd1);

    @(negedge clk);
    mon_en = 0;
    drv_en = 0;
    check("memwr_waiting", 64'({bus.memWr, bus.iorD, bus.insDone}), 64'b110);
    #1;
    rstn = 1'b0;
    #1;
    check("reset_abandons_memwr", 64'(bus.memWr), 64'd0);
    check("reset_mid_outputs", 64'(all_outs()), 64'd0);
    check("reset_mid_ir", 64'(bus.ir), 64'd0);
    check("retired_count", 64'(retired), 64'(n_prog - 1));
    check("pending_store", 64'(exp_q.size()), 64'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
